// File: rtl/goertzel_bin_scheduler_if.sv
// Handshake between the bin scheduler (master) and the external Goertzel core (slave).
// The core gets a start pulse, a clock enable and a coefficient, and returns a done pulse with T1/T2.
interface goertzel_bin_scheduler_if #(
    parameter int D_W = 16
);
    logic                  core_start;
    logic                  core_enable;
    logic [D_W-1:0]        core_coeff;
    logic                  core_done;
    logic signed [D_W-1:0] core_T1;
    logic signed [D_W-1:0] core_T2;

    modport master (
        output core_start,
        output core_enable,
        output core_coeff,
        input  core_done,
        input  core_T1,
        input  core_T2
    );

    modport slave (
        input  core_start,
        input  core_enable,
        input  core_coeff,
        output core_done,
        output core_T1,
        output core_T2
    );
endinterface

// File: rtl/goertzel_bin_scheduler.sv
// Sweeps a Goertzel core over the enabled frequency bins, one coefficient per bin,
// capturing each bin's T1/T2 result and flagging a core that never answers.
module goertzel_bin_scheduler #(
    parameter int D_W     = 16,
    parameter int N_BINS  = 8,
    parameter int TIMEOUT = 2047,
    localparam int BIN_W  = (N_BINS > 1) ? $clog2(N_BINS) : 1
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     coeff_wr_en,
    input  logic [BIN_W-1:0]         coeff_wr_addr,
    input  logic [D_W-1:0]           coeff_wr_data,
    input  logic [N_BINS-1:0]        bin_mask,
    input  logic                     sweep_start,
    goertzel_bin_scheduler_if.master core_bus,
    output logic                     res_valid,
    output logic [BIN_W-1:0]         res_bin,
    output logic signed [D_W-1:0]    res_T1,
    output logic signed [D_W-1:0]    res_T2,
    output logic                     busy,
    output logic                     sweep_done,
    output logic                     err_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    state_t                state_reg;
    logic [BIN_W-1:0]      bin_reg;
    logic [N_BINS-1:0]     mask_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [D_W-1:0]        coeff_reg;
    logic [D_W-1:0]        tbl_reg [N_BINS];
    logic [BIN_W-1:0]      res_bin_reg;
    logic signed [D_W-1:0] res_t1_reg;
    logic signed [D_W-1:0] res_t2_reg;
    logic                  start_reg;
    logic                  valid_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  err_reg;

    // Reset must clear every entry, so the table lives in flops rather than block RAM.
    genvar gi;
    generate
        for (gi = 0; gi < N_BINS; gi++) begin : g_tbl
            always_ff @(posedge sys_clk) begin
                if (!rst_n) begin
                    tbl_reg[gi] <= '0;
                end else if (coeff_wr_en && (coeff_wr_addr == BIN_W'(gi))) begin
                    tbl_reg[gi] <= coeff_wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            bin_reg     <= '0;
            mask_reg    <= '0;
            cnt_reg     <= '0;
            coeff_reg   <= '0;
            res_bin_reg <= '0;
            res_t1_reg  <= '0;
            res_t2_reg  <= '0;
            start_reg   <= 1'b0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            start_reg <= 1'b0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (sweep_start) begin
                        mask_reg  <= bin_mask;
                        err_reg   <= 1'b0;
                        bin_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    if (mask_reg[bin_reg]) begin
                        coeff_reg <= tbl_reg[bin_reg];
                        start_reg <= 1'b1;
                        state_reg <= START;
                    end else begin
                        state_reg <= CAPTURE;
                    end
                end
                START: begin
                    cnt_reg   <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // A done arriving in the terminal-count cycle is still accepted.
                    if (core_bus.core_done) begin
                        res_t1_reg  <= core_bus.core_T1;
                        res_t2_reg  <= core_bus.core_T2;
                        res_bin_reg <= bin_reg;
                        valid_reg   <= 1'b1;
                        state_reg   <= CAPTURE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                            err_reg   <= 1'b1;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                CAPTURE: begin
                    if (bin_reg == BIN_W'(N_BINS - 1)) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        bin_reg   <= bin_reg + 1'b1;
                        state_reg <= LOAD;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign core_bus.core_start  = start_reg;
    assign core_bus.core_enable = busy_reg;
    assign core_bus.core_coeff  = coeff_reg;
    assign res_valid            = valid_reg;
    assign res_bin              = res_bin_reg;
    assign res_T1               = res_t1_reg;
    assign res_T2               = res_t2_reg;
    assign busy                 = busy_reg;
    assign sweep_done           = done_reg;
    assign err_timeout          = err_reg;
endmodule

// File: tb/tb_goertzel_bin_scheduler.sv
// Randomized sweeps of the bin scheduler against a bin-list reference model;
// the bench also plays the Goertzel core with a programmable response latency.
module tb_goertzel_bin_scheduler;
    localparam int TIMEOUT = 2047;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        coeff_wr_en;
    logic [2:0]  coeff_wr_addr;
    logic [15:0] coeff_wr_data;
    logic [7:0]  bin_mask;
    logic        sweep_start;
    logic        res_valid;
    logic [2:0]  res_bin;
    logic [15:0] res_T1;
    logic [15:0] res_T2;
    logic        busy;
    logic        sweep_done;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    logic [15:0] tbl_m [8];

    goertzel_bin_scheduler_if #(.D_W(16)) core_if ();

    goertzel_bin_scheduler #(
        .D_W    (16),
        .N_BINS (8),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .coeff_wr_en  (coeff_wr_en),
        .coeff_wr_addr(coeff_wr_addr),
        .coeff_wr_data(coeff_wr_data),
        .bin_mask     (bin_mask),
        .sweep_start  (sweep_start),
        .core_bus     (core_if.master),
        .res_valid    (res_valid),
        .res_bin      (res_bin),
        .res_T1       (res_T1),
        .res_T2       (res_T2),
        .busy         (busy),
        .sweep_done   (sweep_done),
        .err_timeout  (err_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {28'd0, busy, core_if.core_enable, core_if.core_start, res_valid}, 32'd0);
        check({tag, "_flags"}, {30'd0, sweep_done, err_timeout}, 32'd0);
        check({tag, "_res_bin"}, {29'd0, res_bin}, 32'd0);
        check({tag, "_res_t"}, {res_T1, res_T2}, 32'd0);
        check({tag, "_coeff"}, {16'd0, core_if.core_coeff}, 32'd0);
    endtask

    task automatic write_coeff(input int a, input logic [15:0] d);
        @(negedge sys_clk);
        coeff_wr_en   = 1'b1;
        coeff_wr_addr = 3'(a);
        coeff_wr_data = d;
        tbl_m[a]      = d;
        @(negedge sys_clk);
        coeff_wr_en   = 1'b0;
    endtask

    // One sweep: the enabled bins are visited in ascending order; an enabled bin costs
    // LOAD + START + lat WAIT cycles + CAPTURE, a skipped bin LOAD + CAPTURE, plus one DONE.
    // Without a core response the sweep ends in DONE after TIMEOUT WAIT cycles of the first enabled bin.
    task automatic run_sweep(input logic [7:0] mask, input int lat, input bit respond,
                             input bit hold, input int abort_at, input bit fixed_vals,
                             input bit wr_during);
        int          en_bins[$];
        int          exp_bin_q[$];
        logic [15:0] exp_t1_q[$];
        logic [15:0] exp_t2_q[$];
        int          exp_cycles;
        int          exp_starts;
        bit          to_case;
        int          cyc;
        int          starts;
        int          valids;
        int          cd;
        int          cur_bin;
        int          last_bin;
        logic [15:0] last_t1;
        logic [15:0] last_t2;
        logic [15:0] coeff_at_start;
        logic [15:0] t1;
        logic [15:0] t2;
        bit          seen_done;
        bit          aborted;
        int          wa;
        logic [15:0] wd;

        for (int b = 0; b < 8; b++) if (mask[b]) en_bins.push_back(b);
        to_case = !respond && (en_bins.size() > 0);
        if (to_case) begin
            exp_cycles = 2 * en_bins[0] + 2 + TIMEOUT + 1;
            exp_starts = 1;
        end else begin
            exp_cycles = 1;
            for (int b = 0; b < 8; b++) exp_cycles += mask[b] ? (lat + 3) : 2;
            exp_starts = en_bins.size();
        end
        cyc = 0; starts = 0; valids = 0; cd = 0; cur_bin = 0; last_bin = 0;
        last_t1 = '0; last_t2 = '0; coeff_at_start = '0;
        seen_done = 1'b0; aborted = 1'b0;

        @(negedge sys_clk);
        bin_mask    = mask;
        sweep_start = 1'b1;
        while (!seen_done && !aborted && cyc < exp_cycles + 50) begin
            @(negedge sys_clk);
            cyc++;
            if (!hold) sweep_start = 1'b0;
            core_if.core_done = 1'b0;
            coeff_wr_en       = 1'b0;
            check("busy_enable", {30'd0, busy, core_if.core_enable}, 32'd3);
            check("err_timeout", {31'd0, err_timeout}, {31'd0, to_case && (cyc == exp_cycles)});
            if (core_if.core_start) begin
                if (starts < en_bins.size()) begin
                    cur_bin = en_bins[starts];
                    check("start_coeff", {16'd0, core_if.core_coeff}, {16'd0, tbl_m[cur_bin]});
                end else begin
                    check("extra_start", 32'd1, 32'd0);
                end
                coeff_at_start = core_if.core_coeff;
                starts++;
                cd = lat;
                if (wr_during) begin
                    wa = $urandom_range(0, 7);
                    wd = 16'($urandom);
                    coeff_wr_en   = 1'b1;
                    coeff_wr_addr = 3'(wa);
                    coeff_wr_data = wd;
                    tbl_m[wa]     = wd;
                end
                if (abort_at != 0 && starts == abort_at) aborted = 1'b1;
            end else if (respond && cd > 0) begin
                cd--;
                if (cd == 0) begin
                    t1 = fixed_vals ? 16'(cur_bin) : 16'($urandom);
                    t2 = fixed_vals ? 16'(0 - cur_bin) : 16'($urandom);
                    core_if.core_done = 1'b1;
                    core_if.core_T1   = t1;
                    core_if.core_T2   = t2;
                    exp_bin_q.push_back(cur_bin);
                    exp_t1_q.push_back(t1);
                    exp_t2_q.push_back(t2);
                end
            end
            if (res_valid) begin
                valids++;
                $display("result bin=%0d T1=%h T2=%h coeff=%h", res_bin, res_T1, res_T2, core_if.core_coeff);
                if (exp_bin_q.size() > 0) begin
                    last_bin = exp_bin_q.pop_front();
                    last_t1  = exp_t1_q.pop_front();
                    last_t2  = exp_t2_q.pop_front();
                    check("res_bin", {29'd0, res_bin}, 32'(last_bin));
                    check("res_t1_t2", {res_T1, res_T2}, {last_t1, last_t2});
                    check("coeff_held", {16'd0, core_if.core_coeff}, {16'd0, coeff_at_start});
                end else begin
                    check("extra_res_valid", 32'd1, 32'd0);
                end
            end
            if (sweep_done) seen_done = 1'b1;
        end

        if (aborted) begin
            repeat (3) @(negedge sys_clk);
            coeff_wr_en = 1'b0;
            check("abort_valids", 32'(valids), 32'(abort_at - 1));
            check("abort_no_done", {31'd0, seen_done}, 32'd0);
            $display("sweep mask=%h aborted after %0d starts", mask, starts);
        end else begin
            check("sweep_cycles", 32'(cyc), 32'(exp_cycles));
            check("start_count", 32'(starts), 32'(exp_starts));
            check("valid_count", 32'(valids), to_case ? 32'd0 : 32'(en_bins.size()));
            $display("sweep mask=%h lat=%0d cycles=%0d starts=%0d results=%0d err=%0d",
                     mask, lat, cyc, starts, valids, err_timeout);
            @(negedge sys_clk);
            coeff_wr_en = 1'b0;
            check("post_idle", {28'd0, busy, core_if.core_enable, sweep_done, res_valid}, 32'd0);
            check("err_sticky", {31'd0, err_timeout}, {31'd0, to_case});
            if (valids > 0) begin
                check("res_hold", {13'd0, res_bin, res_T1}, {13'd0, 3'(last_bin), last_t1});
            end
        end
    endtask

    initial begin
        int          acc;
        logic [7:0]  m;
        rst_n             = 1'b0;
        coeff_wr_en       = 1'b0;
        coeff_wr_addr     = '0;
        coeff_wr_data     = '0;
        bin_mask          = '0;
        sweep_start       = 1'b0;
        core_if.core_done = 1'b0;
        core_if.core_T1   = '0;
        core_if.core_T2   = '0;
        for (int i = 0; i < 8; i++) tbl_m[i] = '0;

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Reference coefficients 0x4000+bin, slow core, T1 = bin, T2 = -bin.
        for (int i = 0; i < 8; i++) write_coeff(i, 16'h4000 + 16'(i));
        run_sweep(8'hFF, 1030, 1'b1, 1'b0, 0, 1'b1, 1'b0);

        // Only the two end bins enabled.
        run_sweep(8'b1000_0001, $urandom_range(2, 40), 1'b1, 1'b0, 0, 1'b0, 1'b0);

        // Empty mask: sixteen LOAD/skip cycles then DONE.
        run_sweep(8'h00, 5, 1'b1, 1'b0, 0, 1'b0, 1'b0);

        // Random masks and latencies, with table rewrites landing mid-sweep.
        for (int s = 0; s < 5; s++) begin
            write_coeff($urandom_range(0, 7), 16'($urandom));
            m = 8'($urandom);
            run_sweep(m, $urandom_range(1, 30), 1'b1, 1'b0, 0, 1'b0, 1'b1);
        end

        // Silent core: timeout on the first enabled bin, flag stays set until the next sweep.
        run_sweep(8'b0010_0100, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        // Done exactly in the terminal-count cycle wins over the timeout.
        run_sweep(8'b0000_1000, TIMEOUT, 1'b1, 1'b0, 0, 1'b0, 1'b0);

        // sweep_start held high, reset during WAIT of bin 3.
        for (int i = 0; i < 8; i++) write_coeff(i, 16'h1000 + 16'(i * 3));
        run_sweep(8'hFF, 20, 1'b1, 1'b1, 4, 1'b0, 1'b0);
        @(negedge sys_clk);
        rst_n       = 1'b0;
        sweep_start = 1'b0;
        @(negedge sys_clk);
        check_all_zero("midsweep_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tbl_m[i] = '0;
        acc = 0;
        repeat (30) begin
            @(negedge sys_clk);
            acc = acc | {28'd0, busy, sweep_done, core_if.core_start, res_valid};
        end
        check("idle_after_reset", 32'(acc), 32'd0);

        // The table was cleared by reset, so every start presents a zero coefficient.
        run_sweep(8'b0101_1010, 4, 1'b1, 1'b0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
